// File: rtl/vec_mem_pkg.sv
// vec_mem_pkg: shared types and defaults for the sram byte-port arbiter
package vec_mem_pkg;
    localparam int ADDR_W_DEF = 25;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_LDR, REQ_CPU, REQ_DMA} req_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [7:0]            data;
        logic                  we;
    } mem_cmd_t;
endpackage

// File: rtl/mem_arb_fifo.sv
// mem_arb_fifo: 2-entry loader write buffer with sticky drop flag
module mem_arb_fifo
    import vec_mem_pkg::*;
(
    input  logic     clk_sys,
    input  logic     reset_n,
    input  logic     i_push,
    input  mem_cmd_t i_din,
    input  logic     i_pop,
    input  logic     i_clr_ovf,
    output mem_cmd_t o_head,
    output logic     o_empty,
    output logic     o_overflow
);
    mem_cmd_t   r_mem [2];
    logic       r_wp, r_rp, r_ovf;
    logic [1:0] r_cnt;
    logic       w_full, w_push, w_pop;

    assign w_full  = r_cnt == 2'd2;
    assign w_pop   = i_pop & (r_cnt != 2'd0);
    // a pop in the same cycle frees a slot, so a full buffer still accepts
    assign w_push  = i_push & (~w_full | w_pop);
    assign o_head  = r_mem[r_rp];
    assign o_empty = r_cnt == 2'd0;
    assign o_overflow = r_ovf;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wp     <= 1'b0;
            r_rp     <= 1'b0;
            r_cnt    <= 2'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= i_din;
                r_wp        <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
            r_ovf <= (r_ovf & ~i_clr_ovf) | (i_push & ~w_push);
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the sram byte port between loader, CPU and DMA requesters
module mem_arbiter
    import vec_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ldr_active,
    input  logic              ldr_wr,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_data,
    output logic              ldr_overflow,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_din,
    output logic [7:0]        dma_dout,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ready,
    output logic              busy,
    output logic              timeout_err
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        r_state, w_next;
    req_t          r_who, w_grant;
    mem_cmd_t      r_cmd, w_sel, w_head;
    logic [SW-1:0] r_starve;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_cpu_dout, r_dma_dout, w_rdata;
    logic          r_ldr_d, r_cpu_ack, r_dma_ack, r_tmo_err;
    logic          w_empty, w_starved, w_tmo_hit, w_done;

    mem_arb_fifo u_fifo (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_push     (ldr_wr),
        .i_din      (mem_cmd_t'({ldr_addr, ldr_data, 1'b1})),
        .i_pop      (w_grant == REQ_LDR),
        .i_clr_ovf  (ldr_active & ~r_ldr_d),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_overflow (ldr_overflow)
    );

    assign w_starved = dma_req & (r_starve == SW'(STARVE_MAX));
    assign w_tmo_hit = (r_state == WAIT) & ~mem_ready & (r_tmo == TW'(TIMEOUT - 1));
    assign w_done    = (r_state == WAIT) & (mem_ready | w_tmo_hit);
    assign w_rdata   = mem_ready ? mem_dout : 8'hFF;

    // buffered loader writes always win; hosts are locked out while the loader owns memory
    always_comb begin
        w_grant = REQ_NONE;
        if (r_state == IDLE)
            w_grant = !w_empty   ? REQ_LDR  :
                      ldr_active ? REQ_NONE :
                      w_starved  ? REQ_DMA  :
                      cpu_req    ? REQ_CPU  :
                      dma_req    ? REQ_DMA  : REQ_NONE;
        w_sel = w_grant == REQ_LDR ? w_head :
                w_grant == REQ_CPU ? mem_cmd_t'({cpu_addr, cpu_din, cpu_we}) :
                                     mem_cmd_t'({dma_addr, dma_din, dma_we});
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant != REQ_NONE) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_who      <= REQ_NONE;
            r_cmd      <= '0;
            r_starve   <= '0;
            r_tmo      <= '0;
            r_cpu_dout <= 8'h00;
            r_dma_dout <= 8'h00;
            r_ldr_d    <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_dma_ack  <= 1'b0;
            r_tmo_err  <= 1'b0;
        end else begin
            r_ldr_d   <= ldr_active;
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            r_tmo     <= (r_state == WAIT) ? r_tmo + 1'b1 : '0;
            if (w_grant != REQ_NONE) begin
                r_who <= w_grant;
                r_cmd <= w_sel;
            end
            if (w_grant == REQ_DMA)
                r_starve <= '0;
            else if (w_grant == REQ_CPU && dma_req && r_starve != SW'(STARVE_MAX))
                r_starve <= r_starve + 1'b1;
            if (w_done) begin
                r_cpu_ack <= r_who == REQ_CPU;
                r_dma_ack <= r_who == REQ_DMA;
                if (r_who == REQ_CPU && (w_tmo_hit || !r_cmd.we)) r_cpu_dout <= w_rdata;
                if (r_who == REQ_DMA && (w_tmo_hit || !r_cmd.we)) r_dma_dout <= w_rdata;
                if (w_tmo_hit) r_tmo_err <= 1'b1;
            end
        end
    end

    assign mem_addr    = r_cmd.addr;
    assign mem_din     = r_cmd.data;
    assign mem_we      = (r_state == ISSUE) & r_cmd.we;
    assign mem_rd      = (r_state == ISSUE) & ~r_cmd.we;
    assign cpu_ack     = r_cpu_ack;
    assign dma_ack     = r_dma_ack;
    assign cpu_dout    = r_cpu_dout;
    assign dma_dout    = r_dma_dout;
    assign busy        = r_state != IDLE;
    assign timeout_err = r_tmo_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors and corner-case sequences for mem_arbiter
module tb_mem_arbiter;
    localparam int AW = 25;

    logic          clk_sys = 1'b0, reset_n = 1'b0;
    logic          ldr_active = 1'b0, ldr_wr = 1'b0, ldr_overflow;
    logic [AW-1:0] ldr_addr = '0, cpu_addr = '0, dma_addr = '0, mem_addr;
    logic [7:0]    ldr_data = '0, cpu_din = '0, dma_din = '0, mem_dout = '0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [7:0]    cpu_dout, dma_dout, mem_din;
    logic          cpu_ack, dma_ack, mem_we, mem_rd, mem_ready = 1'b0, busy, timeout_err;

    int            checks = 0, errors = 0;
    int            ncpu = 0, ndma = 0, both = 0;
    logic          hold = 1'b0;
    logic [7:0]    rsp_data = 8'h00;
    logic [33:0]   wlog [$];

    typedef struct {
        logic          dma;
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    din;
        int            d;
        logic          early;
        logic [7:0]    rdata;
        int            lat;
        logic [7:0]    dout;
    } vec_t;
    vec_t tbl [6];

    mem_arbiter dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ldr_active(ldr_active), .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_data(ldr_data),
        .ldr_overflow(ldr_overflow),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din),
        .dma_dout(dma_dout), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_ready(mem_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {mem_addr, mem_din, mem_we, mem_rd, cpu_ack, dma_ack, cpu_dout, dma_dout,
                 busy, timeout_err, ldr_overflow}, 64'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // memory answers every strobe one cycle later; logs {we, addr, din} of each strobe
    task automatic respond(input int n);
        for (int i = 0; i < n; i++) begin
            logic pend;
            if (mem_we && mem_rd) both++;
            if (mem_we || mem_rd) wlog.push_back({mem_we, mem_addr, mem_din});
            if (cpu_ack) begin ncpu++; if (!hold) cpu_req = 1'b0; end
            if (dma_ack) begin ndma++; if (!hold) dma_req = 1'b0; end
            pend = mem_we | mem_rd;
            mem_dout = rsp_data;
            tick();
            mem_ready = pend;
        end
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int c, ack_c, nrd, nwe, other;
        logic addr_ok, din_ok;
        c = 0; ack_c = -1; nrd = 0; nwe = 0; other = 0; addr_ok = 1'b1; din_ok = 1'b1;
        if (v.dma) begin dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_din = v.din; end
        else       begin cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_din = v.din; end
        while (ack_c < 0 && c < 40) begin
            tick();
            c++;
            mem_ready = (c == 1 + v.d) || (v.early && c == 1);
            mem_dout  = (v.early && c == 1) ? 8'h11 : v.rdata;
            if (mem_rd) nrd++;
            if (mem_we) begin nwe++; if (mem_din !== v.din) din_ok = 1'b0; end
            if (busy && mem_addr !== v.addr) addr_ok = 1'b0;
            if (v.dma ? cpu_ack : dma_ack) other++;
            if (v.dma ? dma_ack : cpu_ack) begin
                ack_c = c;
                cpu_req = 1'b0;
                dma_req = 1'b0;
            end
        end
        mem_ready = 1'b0;
        chk($sformatf("v%0d_latency", k), ack_c, v.lat);
        chk($sformatf("v%0d_rd_pulses", k), nrd, v.we ? 0 : 1);
        chk($sformatf("v%0d_we_pulses", k), nwe, v.we ? 1 : 0);
        chk($sformatf("v%0d_addr_stable", k), addr_ok, 1);
        chk($sformatf("v%0d_din", k), din_ok, 1);
        chk($sformatf("v%0d_other_ack", k), other, 0);
        chk($sformatf("v%0d_dout", k), v.dma ? dma_dout : cpu_dout, v.dout);
    endtask

    initial begin
        int c;
        logic [AW-1:0] ea;
        tbl[0] = '{1'b0, 1'b0, 25'h0000100, 8'h00, 4, 1'b0, 8'h5A, 6, 8'h5A};
        tbl[1] = '{1'b0, 1'b1, 25'h1ABCDEF, 8'h3C, 1, 1'b0, 8'hEE, 3, 8'h5A};
        tbl[2] = '{1'b1, 1'b0, 25'h00000FF, 8'h00, 2, 1'b0, 8'hA5, 4, 8'hA5};
        tbl[3] = '{1'b1, 1'b1, 25'h1FFFFFF, 8'h77, 3, 1'b0, 8'h00, 5, 8'hA5};
        tbl[4] = '{1'b0, 1'b0, 25'h0000000, 8'h00, 1, 1'b1, 8'hC3, 3, 8'hC3};
        tbl[5] = '{1'b1, 1'b0, 25'h0123456, 8'h00, 6, 1'b0, 8'h00, 8, 8'h00};

        tick();
        tick();
        chk_zero("reset_in_reset");
        reset_n = 1'b1;
        tick();
        chk_zero("reset_after_release");

        for (int k = 0; k < 6; k++) run_vec(k, tbl[k]);

        // loader: three strobes while the first write is still waiting on memory
        ldr_active = 1'b1;
        ldr_wr = 1'b1; ldr_addr = 25'h0000010; ldr_data = 8'hD0;
        tick();
        ldr_wr = 1'b0;
        tick();
        chk("ldr0_strobe", {mem_we, mem_rd, mem_addr, mem_din}, {2'b10, 25'h0000010, 8'hD0});
        tick();
        ldr_wr = 1'b1; ldr_addr = 25'h0000011; ldr_data = 8'hD1;
        tick();
        ldr_addr = 25'h0000012; ldr_data = 8'hD2;
        tick();
        ldr_addr = 25'h0000013; ldr_data = 8'hD3;
        tick();
        ldr_wr = 1'b0;
        chk("ldr_overflow_set", ldr_overflow, 1);
        chk("ldr_still_waiting", busy, 1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        wlog.delete();
        respond(12);
        chk("ldr_write_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("ldr_write1", wlog[0], {1'b1, 25'h0000011, 8'hD1});
            chk("ldr_write2", wlog[1], {1'b1, 25'h0000012, 8'hD2});
        end
        ldr_active = 1'b0;
        tick();
        chk("ldr_overflow_sticky", ldr_overflow, 1);
        ldr_active = 1'b1;
        tick();
        chk("ldr_overflow_cleared", ldr_overflow, 0);

        // CPU held off while the loader owns memory
        ncpu = 0; wlog.delete(); rsp_data = 8'h42;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000100; cpu_din = 8'h00;
        ldr_wr = 1'b1; ldr_addr = 25'h0000020; ldr_data = 8'hB0;
        tick();
        ldr_addr = 25'h0000021; ldr_data = 8'hB1;
        tick();
        ldr_wr = 1'b0;
        respond(14);
        chk("lock_no_cpu_ack", ncpu, 0);
        chk("lock_ldr_writes", wlog.size(), 2);
        ldr_active = 1'b0;
        respond(8);
        chk("lock_cpu_ack_once", ncpu, 1);
        chk("lock_total_strobes", wlog.size(), 3);
        if (wlog.size() == 3) chk("lock_cpu_last", wlog[2][33:8], {1'b0, 25'h0000100});
        chk("lock_cpu_dout", cpu_dout, 8'h42);

        // CPU and DMA both held: eight CPU grants then one DMA, repeating
        mem_ready = 1'b0;
        do_reset();
        wlog.delete(); hold = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000100;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 25'h0000200;
        respond(60);
        cpu_req = 1'b0; dma_req = 1'b0; hold = 1'b0;
        respond(6);
        chk("starve_grants", wlog.size() >= 18, 1);
        for (int i = 0; i < 18 && i < wlog.size(); i++) begin
            ea = (i % 9 == 8) ? 25'h0000200 : 25'h0000100;
            chk($sformatf("starve_grant%0d", i), wlog[i][32:8], ea);
        end

        // CPU read with no mem_ready: forced completion
        mem_ready = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000100;
        tick();
        chk("tmo_strobe", mem_rd, 1);
        c = 0;
        while (!cpu_ack && c < 400) begin
            tick();
            c++;
        end
        cpu_req = 1'b0;
        chk("tmo_latency", c, 256);
        chk("tmo_dout", cpu_dout, 8'hFF);
        chk("tmo_err", timeout_err, 1);

        // reset in the middle of a DMA write, CPU waiting behind it
        tick();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 25'h0000300; dma_din = 8'h99;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000100;
        tick();
        chk("rst_in_wait", busy, 1);
        tick();
        reset_n = 1'b0;
        dma_req = 1'b0;
        #1;
        chk_zero("rst_async_outputs");
        tick();
        tick();
        chk_zero("rst_held_outputs");
        reset_n = 1'b1;
        ncpu = 0; ndma = 0; both = 0; wlog.delete(); rsp_data = 8'h6B;
        respond(8);
        chk("rst_cpu_ack", ncpu, 1);
        chk("rst_no_dma_ack", ndma, 0);
        chk("rst_strobes", wlog.size(), 1);
        if (wlog.size() == 1) chk("rst_cpu_read", wlog[0][33:8], {1'b0, 25'h0000100});
        chk("rst_cpu_dout", cpu_dout, 8'h6B);
        chk("strobe_exclusive", both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
